// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array processing elements.
// Saturation bounds are returned wide and truncated to AW by the user.
package sa_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 24;
    localparam int AW_MAX = 128;

    typedef struct packed {
        logic vld;
        logic first;
    } pe_tag_t;

    function automatic logic [AW_MAX-1:0] sat_max(input int aw, input bit sgn);
        logic [AW_MAX-1:0] r;
        r = (AW_MAX'(1) << aw) - AW_MAX'(1);
        if (sgn) begin
            r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [AW_MAX-1:0] sat_min(input int aw, input bit sgn);
        return sgn ? (AW_MAX'(1) << (aw - 1)) : '0;
    endfunction

endpackage

// File: rtl/sa_mac_sat.sv
// Combinational accumulate step: extend the product to AW, add at AW+1 bits,
// flag overflow and optionally clamp to the representable range.
module sa_mac_sat import sa_pkg::*; #(
    parameter int PW     = 16,
    parameter int AW     = 24,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic [AW-1:0] acc,
    input  logic [PW-1:0] prod,
    output logic [AW-1:0] prod_ext,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    localparam bit SGN = (SIGNED != 0);
    localparam logic [AW-1:0] MAX_V = AW'(sat_max(AW, SGN));
    localparam logic [AW-1:0] MIN_V = AW'(sat_min(AW, SGN));

    generate
        if (AW > PW) begin : g_ext
            assign prod_ext = {{(AW-PW){SGN & prod[PW-1]}}, prod};
        end else begin : g_noext
            assign prod_ext = prod;
        end
    endgenerate

    logic [AW:0] sum_w;
    assign sum_w = {SGN & acc[AW-1], acc} + {SGN & prod_ext[AW-1], prod_ext};

    // Signed overflow: operands agree in sign but the result does not.
    assign ovf = SGN ? ((acc[AW-1] == prod_ext[AW-1]) && (sum_w[AW-1] != acc[AW-1]))
                     : sum_w[AW];

    always_comb begin
        sum = sum_w[AW-1:0];
        if ((SAT != 0) && ovf) begin
            sum = (SGN && acc[AW-1]) ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/sa_pe_os.sv
// Output-stationary MAC PE: forwards A east and B south, accumulates tagged
// products, and shifts finished results south through a drain register.
module sa_pe_os import sa_pkg::*; #(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int SIGNED   = 0,
    parameter int SAT      = 1,
    parameter int MUL_PIPE = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [DW-1:0] A_IN,
    input  logic          A_VLD_IN,
    input  logic          A_FIRST_IN,
    input  logic [DW-1:0] B_IN,
    input  logic          B_VLD_IN,
    output logic [DW-1:0] A_OUT,
    output logic          A_VLD_OUT,
    output logic          A_FIRST_OUT,
    output logic [DW-1:0] B_OUT,
    output logic          B_VLD_OUT,
    input  logic          DRAIN,
    input  logic [AW-1:0] C_IN,
    input  logic          C_VLD_IN,
    output logic [AW-1:0] C_OUT,
    output logic          C_VLD_OUT,
    output logic          OVF
);

    localparam int PW  = 2 * DW;
    localparam bit SGN = (SIGNED != 0);

    logic [DW-1:0] a_reg, b_reg;
    pe_tag_t       a_tag_reg;
    logic          b_vld_reg;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            a_reg     <= '0;
            b_reg     <= '0;
            a_tag_reg <= '0;
            b_vld_reg <= 1'b0;
        end else if (EN) begin
            a_reg     <= A_IN;
            b_reg     <= B_IN;
            a_tag_reg <= '{vld: A_VLD_IN, first: A_FIRST_IN};
            b_vld_reg <= B_VLD_IN;
        end
    end

    assign A_OUT       = a_reg;
    assign A_VLD_OUT   = a_tag_reg.vld;
    assign A_FIRST_OUT = a_tag_reg.first;
    assign B_OUT       = b_reg;
    assign B_VLD_OUT   = b_vld_reg;

    // Low 2*DW bits of the product of extended operands are exact either way.
    logic [PW-1:0] a_x, b_x, prod_c;
    assign a_x    = {{DW{SGN & a_reg[DW-1]}}, a_reg};
    assign b_x    = {{DW{SGN & b_reg[DW-1]}}, b_reg};
    assign prod_c = a_x * b_x;

    logic [PW-1:0] prod_s;
    logic          mac_s, first_s;

    generate
        if (MUL_PIPE != 0) begin : g_pipe
            logic [PW-1:0] prod_reg;
            pe_tag_t       tag_reg;
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    prod_reg <= '0;
                    tag_reg  <= '0;
                end else if (EN) begin
                    prod_reg <= prod_c;
                    tag_reg  <= '{vld: a_tag_reg.vld & b_vld_reg, first: a_tag_reg.first};
                end
            end
            assign prod_s  = prod_reg;
            assign mac_s   = tag_reg.vld;
            assign first_s = tag_reg.first;
        end else begin : g_comb
            assign prod_s  = prod_c;
            assign mac_s   = a_tag_reg.vld & b_vld_reg;
            assign first_s = a_tag_reg.first;
        end
    endgenerate

    logic [AW-1:0] acc_reg, acc_next, prod_ext, sum;
    logic          ovf_reg, ovf_next, ovf_c;

    sa_mac_sat #(.PW(PW), .AW(AW), .SIGNED(SIGNED), .SAT(SAT)) u_mac (
        .acc      (acc_reg),
        .prod     (prod_s),
        .prod_ext (prod_ext),
        .sum      (sum),
        .ovf      (ovf_c)
    );

    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (mac_s) begin
            if (first_s) begin
                acc_next = prod_ext;
                ovf_next = 1'b0;
            end else begin
                acc_next = sum;
                ovf_next = ovf_reg | ovf_c;
            end
        end
    end

    logic [AW-1:0] c_reg;
    logic          c_vld_reg;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            c_reg     <= '0;
            c_vld_reg <= 1'b0;
        end else if (EN) begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
            // Local capture beats the chain; a coincident C_IN is lost.
            if (DRAIN) begin
                c_reg     <= acc_next;
                c_vld_reg <= 1'b1;
            end else if (C_VLD_IN) begin
                c_reg     <= C_IN;
                c_vld_reg <= 1'b1;
            end else begin
                c_vld_reg <= 1'b0;
            end
        end
    end

    assign C_OUT     = c_reg;
    assign C_VLD_OUT = c_vld_reg;
    assign OVF       = ovf_reg;

endmodule

// File: tb/tb_sa_pe_os.sv
// Bench for sa_pe_os: three configurations share one stimulus stream and are
// compared every cycle against an arithmetic model of the accumulator.
module tb_sa_pe_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, a_vld, a_first, b_vld, drain, c_vld_in;
    logic [7:0]  a_in, b_in;
    logic [23:0] c_in;
    logic [7:0]  a_out [3];
    logic [7:0]  b_out [3];
    logic        a_vld_out [3];
    logic        a_first_out [3];
    logic        b_vld_out [3];
    logic        c_vld_out [3];
    logic        ovf [3];
    logic [23:0] c_out0;
    logic [15:0] c_out1, c_out2;

    sa_pe_os #(.DW(8), .AW(24), .SIGNED(0), .SAT(1), .MUL_PIPE(1)) u0 (
        .CLK(clk), .RST(rst), .EN(en), .A_IN(a_in), .A_VLD_IN(a_vld), .A_FIRST_IN(a_first),
        .B_IN(b_in), .B_VLD_IN(b_vld), .A_OUT(a_out[0]), .A_VLD_OUT(a_vld_out[0]),
        .A_FIRST_OUT(a_first_out[0]), .B_OUT(b_out[0]), .B_VLD_OUT(b_vld_out[0]),
        .DRAIN(drain), .C_IN(c_in), .C_VLD_IN(c_vld_in), .C_OUT(c_out0),
        .C_VLD_OUT(c_vld_out[0]), .OVF(ovf[0]));

    sa_pe_os #(.DW(8), .AW(16), .SIGNED(1), .SAT(1), .MUL_PIPE(0)) u1 (
        .CLK(clk), .RST(rst), .EN(en), .A_IN(a_in), .A_VLD_IN(a_vld), .A_FIRST_IN(a_first),
        .B_IN(b_in), .B_VLD_IN(b_vld), .A_OUT(a_out[1]), .A_VLD_OUT(a_vld_out[1]),
        .A_FIRST_OUT(a_first_out[1]), .B_OUT(b_out[1]), .B_VLD_OUT(b_vld_out[1]),
        .DRAIN(drain), .C_IN(c_in[15:0]), .C_VLD_IN(c_vld_in), .C_OUT(c_out1),
        .C_VLD_OUT(c_vld_out[1]), .OVF(ovf[1]));

    sa_pe_os #(.DW(8), .AW(16), .SIGNED(0), .SAT(0), .MUL_PIPE(1)) u2 (
        .CLK(clk), .RST(rst), .EN(en), .A_IN(a_in), .A_VLD_IN(a_vld), .A_FIRST_IN(a_first),
        .B_IN(b_in), .B_VLD_IN(b_vld), .A_OUT(a_out[2]), .A_VLD_OUT(a_vld_out[2]),
        .A_FIRST_OUT(a_first_out[2]), .B_OUT(b_out[2]), .B_VLD_OUT(b_vld_out[2]),
        .DRAIN(drain), .C_IN(c_in[15:0]), .C_VLD_IN(c_vld_in), .C_OUT(c_out2),
        .C_VLD_OUT(c_vld_out[2]), .OVF(ovf[2]));

    // Configuration of each instance as seen by the model.
    int aw_p  [3] = '{24, 16, 16};
    bit sgn_p [3] = '{1'b0, 1'b1, 1'b0};
    bit sat_p [3] = '{1'b1, 1'b1, 1'b0};
    int lat_p [3] = '{3, 2, 3};

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         mac;
        bit         first;
    } txn_t;

    txn_t       hist[$];
    longint     m_acc [3];
    longint     m_c [3];
    bit         m_ovf [3];
    bit         m_cv [3];
    logic [7:0] m_a, m_b;
    bit         m_av, m_af, m_bv;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One accumulate step in true integer arithmetic, then range handling.
    function automatic void apply(input int i, input txn_t e);
        longint span, pa, pb, p, s, maxv, minv;
        span = longint'(1) << aw_p[i];
        pa   = sgn_p[i] ? longint'($signed(e.a)) : longint'(e.a);
        pb   = sgn_p[i] ? longint'($signed(e.b)) : longint'(e.b);
        p    = pa * pb;
        maxv = sgn_p[i] ? (span / 2 - 1) : (span - 1);
        minv = sgn_p[i] ? -(span / 2) : 0;
        if (e.first) begin
            m_acc[i] = p;
            m_ovf[i] = 1'b0;
        end else begin
            s = m_acc[i] + p;
            if (s > maxv) begin
                m_ovf[i] = 1'b1;
                m_acc[i] = sat_p[i] ? maxv : s - span;
            end else if (s < minv) begin
                m_ovf[i] = 1'b1;
                m_acc[i] = sat_p[i] ? minv : s + span;
            end else begin
                m_acc[i] = s;
            end
        end
    endfunction

    task automatic tick();
        txn_t   e, h;
        longint mask;
        @(posedge clk);
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = 0; m_ovf[i] = 1'b0; m_c[i] = 0; m_cv[i] = 1'b0;
            end
            m_a = '0; m_b = '0; m_av = 1'b0; m_af = 1'b0; m_bv = 1'b0;
        end else if (en) begin
            e.a = a_in; e.b = b_in; e.mac = a_vld && b_vld; e.first = a_first;
            hist.push_back(e);
            for (int i = 0; i < 3; i++) begin
                mask = (longint'(1) << aw_p[i]) - 1;
                if (hist.size() >= lat_p[i]) begin
                    h = hist[hist.size() - lat_p[i]];
                    if (h.mac) apply(i, h);
                end
                if (drain) begin
                    m_c[i] = m_acc[i] & mask; m_cv[i] = 1'b1;
                end else if (c_vld_in) begin
                    m_c[i] = longint'(c_in) & mask; m_cv[i] = 1'b1;
                end else begin
                    m_cv[i] = 1'b0;
                end
            end
            m_a = a_in; m_b = b_in; m_av = a_vld; m_af = a_first; m_bv = b_vld;
        end
        #1;
        chk("c_out0", 64'(c_out0), 64'(m_c[0]));
        chk("c_out1", 64'(c_out1), 64'(m_c[1]));
        chk("c_out2", 64'(c_out2), 64'(m_c[2]));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("c_vld%0d", i), 64'(c_vld_out[i]), 64'(m_cv[i]));
            chk($sformatf("ovf%0d", i), 64'(ovf[i]), 64'(m_ovf[i]));
        end
        chk("a_out", 64'(a_out[0]), 64'(m_a));
        chk("b_out", 64'(b_out[0]), 64'(m_b));
        chk("fwd_tags", 64'({a_vld_out[0], a_first_out[0], b_vld_out[0]}), 64'({m_av, m_af, m_bv}));
        n_txn++;
        $display("txn %0d rst=%0b en=%0b a=%0d b=%0d vld=%0b%0b first=%0b drain=%0b c0=%0d c1=%0d c2=%0d",
                 n_txn, rst, en, a_in, b_in, a_vld, b_vld, a_first, drain, c_out0, c_out1, c_out2);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input bit av, input bit bv, input bit f);
        a_in = a; b_in = b; a_vld = av; b_vld = bv; a_first = f;
        tick();
    endtask

    initial begin
        // Reset wins over EN and over nonzero inputs.
        rst = 1'b0; en = 1'b1; drain = 1'b1; c_vld_in = 1'b1; c_in = 24'h123456;
        a_in = 8'hA5; b_in = 8'h5A; a_vld = 1'b1; b_vld = 1'b1; a_first = 1'b1;
        tick();
        en = 1'b0;
        tick();
        chk("rst_c_out", 64'(c_out0), 64'd0);
        chk("rst_a_out", 64'(a_out[0]), 64'd0);
        chk("rst_c_vld", 64'(c_vld_out[0]), 64'd0);
        chk("rst_ovf", 64'(ovf[0]), 64'd0);

        rst = 1'b1; en = 1'b1; c_vld_in = 1'b0;
        drive(8'd3, 8'd4, 1, 1, 1);
        drive(8'd5, 8'd6, 1, 1, 0);
        drive(8'd255, 8'd255, 1, 1, 0);
        repeat (3) drive(8'd0, 8'd0, 0, 0, 0);
        chk("basic_u0", 64'(c_out0), 64'd65067);
        chk("basic_vld", 64'(c_vld_out[0]), 64'd1);

        en = 1'b0;
        repeat (3) begin
            c_vld_in = 1'b1; c_in = 24'($urandom);
            drive(8'($urandom), 8'($urandom), 1, 1, 1);
        end
        chk("hold_c_out", 64'(c_out0), 64'd65067);
        chk("hold_a_out", 64'(a_out[0]), 64'd0);
        en = 1'b1; c_vld_in = 1'b0;

        drive(8'h80, 8'h80, 1, 1, 1);
        repeat (3) drive(8'd127, 8'd127, 1, 1, 0);
        repeat (3) drive(8'd0, 8'd0, 0, 0, 0);
        chk("sat_u1", 64'(c_out1), 64'd32767);
        chk("sat_ovf_u1", 64'(ovf[1]), 64'd1);
        drive(8'd2, 8'd3, 1, 1, 1);
        repeat (3) drive(8'd0, 8'd0, 0, 0, 0);
        chk("first_u1", 64'(c_out1), 64'd6);
        chk("first_ovf_u1", 64'(ovf[1]), 64'd0);
        chk("first_u0", 64'(c_out0), 64'd6);

        drive(8'd255, 8'd255, 1, 1, 1);
        drive(8'd255, 8'd255, 1, 1, 0);
        repeat (3) drive(8'd0, 8'd0, 0, 0, 0);
        chk("wrap_u2", 64'(c_out2), 64'd64514);
        chk("wrap_ovf_u2", 64'(ovf[2]), 64'd1);
        chk("nowrap_u0", 64'(c_out0), 64'd130050);
        chk("nowrap_ovf_u0", 64'(ovf[0]), 64'd0);

        repeat (4) drive(8'd9, 8'd9, 1, 0, 1);
        chk("gate_a_out", 64'(a_out[0]), 64'd9);
        chk("gate_b_out", 64'(b_out[0]), 64'd9);
        chk("gate_b_vld", 64'(b_vld_out[0]), 64'd0);
        repeat (2) drive(8'd0, 8'd0, 0, 0, 0);
        chk("gate_acc", 64'(c_out0), 64'd130050);
        chk("gate_ovf_u2", 64'(ovf[2]), 64'd1);

        drain = 1'b0; c_vld_in = 1'b1; c_in = 24'd100;
        drive(8'd0, 8'd0, 0, 0, 0);
        chk("chain_100", 64'(c_out0), 64'd100);
        chk("chain_vld", 64'(c_vld_out[0]), 64'd1);
        c_in = 24'd200;
        drive(8'd0, 8'd0, 0, 0, 0);
        chk("chain_200", 64'(c_out0), 64'd200);
        c_vld_in = 1'b0;
        drive(8'd0, 8'd0, 0, 0, 0);
        chk("chain_idle_vld", 64'(c_vld_out[0]), 64'd0);
        chk("chain_idle_hold", 64'(c_out0), 64'd200);
        drain = 1'b1; c_vld_in = 1'b1; c_in = 24'd7;
        drive(8'd0, 8'd0, 0, 0, 0);
        chk("drain_wins", 64'(c_out0), 64'd130050);

        repeat (400) begin
            logic [7:0] ra, rb;
            rst      = ($urandom % 60) != 0;
            en       = ($urandom % 6) != 0;
            drain    = ($urandom % 3) == 0;
            c_vld_in = ($urandom % 2) == 0;
            c_in     = 24'($urandom);
            ra = (($urandom % 4) == 0) ? ((($urandom % 2) == 0) ? 8'hFF : 8'h80) : 8'($urandom);
            rb = (($urandom % 4) == 0) ? ((($urandom % 2) == 0) ? 8'h7F : 8'h80) : 8'($urandom);
            drive(ra, rb, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
